// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the oversampled UART blocks:
//   - parity mode encodings
//   - one-hot receiver FSM state encodings and the state enum built on them
//   - calc_div(): sys_clk cycles per oversample tick
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b11;

  localparam logic [5:0] ST_IDLE    = 6'b000001;
  localparam logic [5:0] ST_START   = 6'b000010;
  localparam logic [5:0] ST_DATA    = 6'b000100;
  localparam logic [5:0] ST_PARITY  = 6'b001000;
  localparam logic [5:0] ST_STOP    = 6'b010000;
  localparam logic [5:0] ST_WAIT_HI = 6'b100000;

  typedef enum logic [5:0] {
    S_IDLE    = ST_IDLE,
    S_START   = ST_START,
    S_DATA    = ST_DATA,
    S_PARITY  = ST_PARITY,
    S_STOP    = ST_STOP,
    S_WAIT_HI = ST_WAIT_HI
  } rx_state_e;

  // Rounded CLK_FRQ / (BAUD * OSR), never below one cycle per tick.
  function automatic int calc_div(input longint clk_frq, input longint baud,
                                  input longint osr);
    longint den;
    longint div;
    den = baud * osr;
    div = (clk_frq + den / 2) / den;
    return (div < 1) ? 1 : int'(div);
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// -----------------------------------------------------------------------------
// uart_rx_os_if
//   Received-word handshake between the UART receiver and its consumer.
//   master : receiver side (drives word, flags, rx_valid; reads rx_ready)
//   slave  : consumer side (reads word, flags, rx_valid; drives rx_ready)
//   Signals:
//     rx_data        received word, LSB = first bit on line
//     rx_valid       word and flags valid, held until accepted
//     rx_ready       consumer accepts when rx_valid & rx_ready
//     rx_parity_err  parity mismatch for this word
//     rx_frame_err   a stop bit sampled 0
//     rx_overrun     an unread word was overwritten by this word
//     rx_break       all data, parity and stop samples were 0
// -----------------------------------------------------------------------------
interface uart_rx_os_if #(
  parameter int DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic                 rx_overrun;
  logic                 rx_break;

  modport master (
    output rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun, rx_break,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun, rx_break,
    output rx_ready
  );

endinterface

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
//   Free-running oversample tick generator: one-cycle pulse every
//   calc_div(CLK_FRQ, BAUD, OSR) sys_clk cycles. With a divider of 1 the
//   tick is high every cycle.
//   Ports:
//     sys_clk  in   system clock
//     rst_n    in   asynchronous reset, active-low
//     tick_o   out  oversample tick
// -----------------------------------------------------------------------------
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FRQ = 100000000,
  parameter int BAUD    = 115200,
  parameter int OSR     = 16
) (
  input  logic sys_clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int            DIV  = calc_div(CLK_FRQ, BAUD, OSR);
  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of process ordering.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_os.sv
// -----------------------------------------------------------------------------
// uart_rx_os
//   Oversampled UART receiver. The line is synchronised, sampled OSR times per
//   bit and each bit is decided by a 3-sample majority vote around mid-bit.
//   Configurable data bits, parity and stop bits; reports parity, framing,
//   overrun and break conditions alongside each word.
//   Ports:
//     sys_clk   in   system clock
//     rst_n     in   asynchronous reset, active-low
//     uart_rxd  in   asynchronous serial line, idle high
//     rx_if     master side of the received-word handshake
// -----------------------------------------------------------------------------
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int         CLK_FRQ   = 100000000,
  parameter int         BAUD      = 115200,
  parameter int         OSR       = 16,
  parameter int         DATA_BITS = 8,
  parameter logic [1:0] PARITY    = PAR_NONE,
  parameter int         STOP_BITS = 1
) (
  input  logic         sys_clk,
  input  logic         rst_n,
  input  logic         uart_rxd,
  uart_rx_os_if.master rx_if
);

  localparam int             OSW       = $clog2(OSR);
  localparam logic [OSW-1:0] OS_V0     = OSW'(OSR / 2 - 1);
  localparam logic [OSW-1:0] OS_V1     = OSW'(OSR / 2);
  localparam logic [OSW-1:0] OS_V2     = OSW'(OSR / 2 + 1);
  localparam logic [OSW-1:0] OS_LAST   = OSW'(OSR - 1);
  localparam logic [3:0]     BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic           STOP_LAST = 1'(STOP_BITS - 1);
  // Encoding 2'b10 is deliberately treated as "no parity".
  localparam bit             HAS_PAR   = (PARITY == PAR_ODD) || (PARITY == PAR_EVEN);

  // ---------------------------------------------------------------- sync/tick
  logic rxd_m_q, rxd_s_q, rxd_s;
  logic tick;

  // Synchroniser resets to the idle level so reset release never fakes a start.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_m_q <= 1'b1;
      rxd_s_q <= 1'b1;
    end else begin
      rxd_m_q <= uart_rxd;
      rxd_s_q <= rxd_m_q;
    end
  end
  assign rxd_s = rxd_s_q;

  uart_baud_tick #(
    .CLK_FRQ(CLK_FRQ),
    .BAUD   (BAUD),
    .OSR    (OSR)
  ) u_tick (
    .sys_clk(sys_clk),
    .rst_n  (rst_n),
    .tick_o (tick)
  );

  // ----------------------------------------------------------- receive FSM
  rx_state_e            state_q, state_d;
  logic [OSW-1:0]       os_cnt_q, os_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 smp0_q, smp0_d, smp1_q, smp1_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 any_one_q, any_one_d;
  logic                 vote, at_vote, bit_end, par_exp;
  logic                 done, done_ferr, done_brk;

  // Third sample is the live synchronised value on the deciding tick.
  assign vote    = (smp0_q & smp1_q) | (smp0_q & rxd_s) | (smp1_q & rxd_s);
  assign at_vote = (os_cnt_q == OS_V2);
  assign bit_end = (os_cnt_q == OS_LAST);
  assign par_exp = (PARITY == PAR_EVEN) ? ^shift_q : ~^shift_q;

  assign done_ferr = ferr_q | ~vote;
  assign done_brk  = ~(any_one_q | vote);

  // NOTE: every combinational output gets a default first, so no path through
  // the case/if tree leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d    = state_q;
    os_cnt_d   = os_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    smp0_d     = smp0_q;
    smp1_d     = smp1_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    any_one_d  = any_one_q;
    done       = 1'b0;

    if (tick) begin
      os_cnt_d = bit_end ? '0 : os_cnt_q + 1'b1;
      if (os_cnt_q == OS_V0) smp0_d = rxd_s;
      if (os_cnt_q == OS_V1) smp1_d = rxd_s;

      case (state_q)
        S_IDLE: begin
          os_cnt_d = '0;
          if (!rxd_s) begin
            state_d    = S_START;
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
            perr_d     = 1'b0;
            ferr_d     = 1'b0;
            any_one_d  = 1'b0;
          end
        end

        S_START: begin
          if (at_vote && vote) begin
            state_d  = S_IDLE;          // glitch, not a start bit
            os_cnt_d = '0;
          end else if (bit_end) begin
            state_d = S_DATA;
          end
        end

        S_DATA: begin
          if (at_vote) begin
            shift_d   = {vote, shift_q[DATA_BITS-1:1]};
            any_one_d = any_one_q | vote;
          end
          if (bit_end) begin
            if (bit_cnt_q == BIT_LAST) state_d = HAS_PAR ? S_PARITY : S_STOP;
            else                       bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end

        S_PARITY: begin
          if (at_vote) begin
            perr_d    = (vote != par_exp);
            any_one_d = any_one_q | vote;
          end
          if (bit_end) state_d = S_STOP;
        end

        S_STOP: begin
          if (at_vote) begin
            ferr_d    = done_ferr;
            any_one_d = any_one_q | vote;
            // Complete on the last stop decision to leave margin for resync.
            if (stop_cnt_q == STOP_LAST) begin
              done     = 1'b1;
              os_cnt_d = '0;
              state_d  = done_ferr ? S_WAIT_HI : S_IDLE;
            end
          end
          if (bit_end) stop_cnt_d = 1'b1;
        end

        S_WAIT_HI: begin
          os_cnt_d = '0;
          if (rxd_s) state_d = S_IDLE;
        end

        default: begin
          state_d  = S_IDLE;
          os_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      os_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      smp0_q     <= 1'b1;
      smp1_q     <= 1'b1;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      any_one_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      os_cnt_q   <= os_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      smp0_q     <= smp0_d;
      smp1_q     <= smp1_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      any_one_q  <= any_one_d;
    end
  end

  // -------------------------------------------------------- output register
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, perr_o_q, ferr_o_q, ovr_q, brk_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      perr_o_q <= 1'b0;
      ferr_o_q <= 1'b0;
      ovr_q    <= 1'b0;
      brk_q    <= 1'b0;
    end else if (done) begin
      data_q   <= shift_q;
      valid_q  <= 1'b1;
      perr_o_q <= perr_q;
      ferr_o_q <= done_ferr;
      brk_q    <= done_brk;
      // Overrun only if the held word is not being accepted this very cycle.
      ovr_q    <= valid_q & ~rx_if.rx_ready;
    end else if (valid_q && rx_if.rx_ready) begin
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end
  end

  assign rx_if.rx_data       = data_q;
  assign rx_if.rx_valid      = valid_q;
  assign rx_if.rx_parity_err = perr_o_q;
  assign rx_if.rx_frame_err  = ferr_o_q;
  assign rx_if.rx_overrun    = ovr_q;
  assign rx_if.rx_break      = brk_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_os
//   Three receivers share clock and reset: ch0 8N1, ch1 7N2, ch2 8E1.
//   The stimulus builds line bit sequences, the reference model derives the
//   expected word/flags from those bits, and a monitor per channel pops and
//   compares on every accepted word.
// -----------------------------------------------------------------------------
module tb_uart_rx_os;
  import uart_pkg::*;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  logic rxd_a = 1'b1, rxd_b = 1'b1, rxd_c = 1'b1;
  logic rdy_a = 1'b1, rdy_b = 1'b1, rdy_c = 1'b1;

  always #5 sys_clk = ~sys_clk;

  uart_rx_os_if #(.DATA_BITS(8)) a_if ();
  uart_rx_os_if #(.DATA_BITS(7)) b_if ();
  uart_rx_os_if #(.DATA_BITS(8)) c_if ();

  assign a_if.rx_ready = rdy_a;
  assign b_if.rx_ready = rdy_b;
  assign c_if.rx_ready = rdy_c;

  uart_rx_os #(.CLK_FRQ(1843200), .BAUD(115200), .OSR(16), .DATA_BITS(8),
               .PARITY(PAR_NONE), .STOP_BITS(1))
    dut_a (.sys_clk(sys_clk), .rst_n(rst_n), .uart_rxd(rxd_a), .rx_if(a_if));

  uart_rx_os #(.CLK_FRQ(1843200), .BAUD(115200), .OSR(16), .DATA_BITS(7),
               .PARITY(PAR_NONE), .STOP_BITS(2))
    dut_b (.sys_clk(sys_clk), .rst_n(rst_n), .uart_rxd(rxd_b), .rx_if(b_if));

  uart_rx_os #(.CLK_FRQ(1843200), .BAUD(115200), .OSR(16), .DATA_BITS(8),
               .PARITY(PAR_EVEN), .STOP_BITS(1))
    dut_c (.sys_clk(sys_clk), .rst_n(rst_n), .uart_rxd(rxd_c), .rx_if(c_if));

  typedef struct packed {
    logic [1:0] ch;
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       ovr;
    logic       brk;
  } word_t;

  word_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    words_a = 0, words_b = 0, words_c = 0;
  bit    hold_a  = 1'b0;

  // ------------------------------------------------------------- helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic set_rxd(input int ch, input logic v);
    case (ch)
      0:       rxd_a = v;
      1:       rxd_b = v;
      default: rxd_c = v;
    endcase
  endtask

  function automatic int cfg_db(input int ch);
    return (ch == 1) ? 7 : 8;
  endfunction

  // 0 none, 1 odd, 2 even
  function automatic int cfg_par(input int ch);
    return (ch == 2) ? 2 : 0;
  endfunction

  function automatic int cfg_sb(input int ch);
    return (ch == 1) ? 2 : 1;
  endfunction

  // Reference model: what a receiver must report for a given line bit sequence
  // (line[0] = start bit, then data LSB first, optional parity, stop bits).
  function automatic word_t model(input int ch, input logic [15:0] line, input int n);
    word_t w;
    int    ones;
    bit    all_zero;
    w        = '0;
    w.ch     = 2'(ch);
    ones     = 0;
    all_zero = 1'b1;
    for (int i = 0; i < cfg_db(ch); i++) begin
      w.data[i] = line[1+i];
      ones += int'(line[1+i]);
    end
    if (cfg_par(ch) != 0) begin
      ones += int'(line[1+cfg_db(ch)]);
      w.perr = (cfg_par(ch) == 2) ? ((ones % 2) != 0) : ((ones % 2) == 0);
    end
    for (int i = 0; i < cfg_sb(ch); i++)
      if (!line[n-cfg_sb(ch)+i]) w.ferr = 1'b1;
    for (int i = 1; i < n; i++)
      if (line[i]) all_zero = 1'b0;
    w.brk = all_zero;
    return w;
  endfunction

  // An unread word on a channel whose consumer is stalled gets replaced.
  task automatic push_expect(input word_t w);
    word_t nw;
    nw = w;
    if (nw.ch == 2'd0 && hold_a && exp_q.size() > 0 && exp_q[$].ch == 2'd0) begin
      void'(exp_q.pop_back());
      nw.ovr = 1'b1;
    end
    exp_q.push_back(nw);
  endtask

  // Bit edges are displaced by up to +/-3 cycles from nominal when jitter is on
  // (non-cumulative: each edge is relative to the ideal grid).
  task automatic drive_line(input int ch, input logic [15:0] line, input int n, input bit jitter);
    int j_prev, j_next;
    j_prev = 0;
    for (int k = 0; k < n; k++) begin
      j_next = (jitter && k < n - 1) ? int'($urandom_range(6)) - 3 : 0;
      set_rxd(ch, line[k]);
      wait_cyc(16 + j_next - j_prev);
      j_prev = j_next;
    end
    set_rxd(ch, 1'b1);
  endtask

  // par_bit < 0 selects the correct parity bit, else the given value is sent.
  task automatic send_frame(input int ch, input logic [8:0] data, input int par_bit,
                            input logic stop_v, input bit jitter);
    logic [15:0] line;
    int          n;
    logic        x;
    line    = '1;
    line[0] = 1'b0;
    x       = 1'b0;
    for (int i = 0; i < cfg_db(ch); i++) begin
      line[1+i] = data[i];
      x ^= data[i];
    end
    n = 1 + cfg_db(ch);
    if (cfg_par(ch) != 0) begin
      if (par_bit < 0) line[n] = (cfg_par(ch) == 2) ? x : ~x;
      else             line[n] = par_bit[0];
      n++;
    end
    for (int i = 0; i < cfg_sb(ch); i++) begin
      line[n] = stop_v;
      n++;
    end
    push_expect(model(ch, line, n));
    drive_line(ch, line, n, jitter);
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      wait_cyc(1);
      t++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d words still pending after 400 cycles, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ------------------------------------------------------------ scoreboard
  task automatic sb_check(input int ch, input logic [8:0] d, input logic pe,
                          input logic fe, input logic ov, input logic bk);
    word_t act, exp;
    act = '{ch: 2'(ch), data: d, perr: pe, ferr: fe, ovr: ov, brk: bk};
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL word_ch%0d: got data=0x%0h pe=%0b fe=%0b ov=%0b brk=%0b, expected no word",
               ch, d, pe, fe, ov, bk);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        n_fail++;
        $display("FAIL word_ch%0d: got ch=%0d data=0x%0h pe=%0b fe=%0b ov=%0b brk=%0b, expected ch=%0d data=0x%0h pe=%0b fe=%0b ov=%0b brk=%0b",
                 ch, act.ch, act.data, act.perr, act.ferr, act.ovr, act.brk,
                 exp.ch, exp.data, exp.perr, exp.ferr, exp.ovr, exp.brk);
      end
    end
  endtask

  always @(negedge sys_clk) begin
    if (rst_n && a_if.rx_valid && rdy_a) begin
      words_a++;
      sb_check(0, {1'b0, a_if.rx_data}, a_if.rx_parity_err, a_if.rx_frame_err,
               a_if.rx_overrun, a_if.rx_break);
    end
  end

  always @(negedge sys_clk) begin
    if (rst_n && b_if.rx_valid && rdy_b) begin
      words_b++;
      sb_check(1, {2'b0, b_if.rx_data}, b_if.rx_parity_err, b_if.rx_frame_err,
               b_if.rx_overrun, b_if.rx_break);
    end
  end

  always @(negedge sys_clk) begin
    if (rst_n && c_if.rx_valid && rdy_c) begin
      words_c++;
      sb_check(2, {1'b0, c_if.rx_data}, c_if.rx_parity_err, c_if.rx_frame_err,
               c_if.rx_overrun, c_if.rx_break);
    end
  end

  // -------------------------------------------------------------- stimulus
  initial begin
    int w0;
    logic [8:0] rd;

    rst_n = 1'b0;
    wait_cyc(3);
    check("rst_out_a", {a_if.rx_valid, a_if.rx_parity_err, a_if.rx_frame_err,
                        a_if.rx_overrun, a_if.rx_break, 1'b0, a_if.rx_data}, 32'h0);
    check("rst_out_b", {b_if.rx_valid, b_if.rx_parity_err, b_if.rx_frame_err,
                        b_if.rx_overrun, b_if.rx_break, 2'b0, b_if.rx_data}, 32'h0);
    check("rst_out_c", {c_if.rx_valid, c_if.rx_parity_err, c_if.rx_frame_err,
                        c_if.rx_overrun, c_if.rx_break, 1'b0, c_if.rx_data}, 32'h0);
    rst_n = 1'b1;
    wait_cyc(10);

    // 8N1 and 7N2 basic words
    w0 = words_a;
    send_frame(0, 9'h05A, -1, 1'b1, 1'b0);
    wait_drain("t1_8n1");
    check("t1_8n1_count", 32'(words_a - w0), 32'd1);
    w0 = words_b;
    send_frame(1, 9'h05A, -1, 1'b1, 1'b0);
    wait_drain("t1_7n2");
    check("t1_7n2_count", 32'(words_b - w0), 32'd1);

    // 8E1 correct and wrong parity
    send_frame(2, 9'h007, -1, 1'b1, 1'b0);
    wait_drain("t2_par_ok");
    send_frame(2, 9'h007, 0, 1'b1, 1'b0);
    wait_drain("t2_par_bad");

    // 4-cycle glitch must not produce a word
    w0 = words_a;
    set_rxd(0, 1'b0);
    wait_cyc(4);
    set_rxd(0, 1'b1);
    wait_cyc(40);
    check("t3_glitch_count", 32'(words_a - w0), 32'd0);
    send_frame(0, 9'h0C3, -1, 1'b1, 1'b0);
    wait_drain("t3_after_glitch");

    // framing error, then break held for three frame times
    send_frame(0, 9'h081, -1, 1'b0, 1'b0);
    wait_drain("t4_frame_err");
    wait_cyc(20);
    w0 = words_a;
    push_expect(model(0, 16'h0000, 10));
    set_rxd(0, 1'b0);
    wait_cyc(480);
    check("t4_break_count", 32'(words_a - w0), 32'd1);
    check("t4_break_pending", 32'(exp_q.size()), 32'd0);
    set_rxd(0, 1'b1);
    wait_cyc(20);
    send_frame(0, 9'h055, -1, 1'b1, 1'b0);
    wait_drain("t4_after_break");

    // overrun with stalled consumer
    rdy_a  = 1'b0;
    hold_a = 1'b1;
    send_frame(0, 9'h011, -1, 1'b1, 1'b0);
    send_frame(0, 9'h022, -1, 1'b1, 1'b0);
    wait_cyc(20);
    check("t5_valid", 32'(a_if.rx_valid), 32'd1);
    check("t5_data", 32'(a_if.rx_data), 32'h22);
    check("t5_overrun", 32'(a_if.rx_overrun), 32'd1);
    rdy_a = 1'b1;
    wait_cyc(1);
    check("t5_valid_clr", 32'(a_if.rx_valid), 32'd0);
    check("t5_overrun_clr", 32'(a_if.rx_overrun), 32'd0);
    hold_a = 1'b0;
    wait_drain("t5_drain");

    // reset in the middle of data bit 4
    w0 = words_a;
    set_rxd(0, 1'b0);
    wait_cyc(16 * 5 + 8);
    rst_n = 1'b0;
    wait_cyc(3);
    check("t6_rst_out", {a_if.rx_valid, a_if.rx_parity_err, a_if.rx_frame_err,
                         a_if.rx_overrun, a_if.rx_break, 1'b0, a_if.rx_data}, 32'h0);
    set_rxd(0, 1'b1);
    rst_n = 1'b1;
    wait_cyc(200);
    check("t6_no_word", 32'(words_a - w0), 32'd0);
    send_frame(0, 9'h03C, -1, 1'b1, 1'b1);
    wait_drain("t6_after_reset");

    // random words with jittered bit edges on every channel
    for (int rep = 0; rep < 6; rep++) begin
      for (int ch = 0; ch < 3; ch++) begin
        rd = 9'($urandom_range(511));
        if (ch == 2 && rep % 2 == 1) send_frame(ch, rd, int'($urandom_range(1)), 1'b1, 1'b1);
        else                         send_frame(ch, rd, -1, 1'b1, 1'b1);
        wait_drain("rand");
        wait_cyc(int'($urandom_range(8)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
